// File: rtl/div_arbiter.sv
// Round-robin sequencer that shares one iterative divider among N requesters and traps b==0.
// Optional macro DIV_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts the divider after TIMEOUT cycles.
module div_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_q,
  output logic [W-1:0]   rsp_r,
  output logic           rsp_err,
  output logic           div_start,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  output logic           div_abort,
  input  logic           div_done,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  owner_q;
  logic          zero_q;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  rsp_valid_q;
  logic [W-1:0]  rsp_q_q;
  logic [W-1:0]  rsp_r_q;
  logic          rsp_err_q;
  logic          div_start_q;
  logic          div_abort_q;
  logic [W-1:0]  div_a_q;
  logic [W-1:0]  div_b_q;
  logic          busy_q;

  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic [PW:0]   scan_s;
  logic [PW-1:0] ptr_d;
  logic [N-1:0]  win_oh_s;
  logic [W-1:0]  win_a_s;
  logic [W-1:0]  win_b_s;
  logic          expire_s;

  // Round-robin search: first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_s      = '0;
    for (int k = 0; k < N; k++) begin
      scan_s = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_s >= (PW+1)'(N)) begin
        scan_s = scan_s - (PW+1)'(N);
      end else begin
        scan_s = scan_s;
      end
      if (!win_found_s && req[scan_s[PW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_s[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner one-hot, its operands and the pointer value that follows it.
  always_comb begin
    win_oh_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
    win_a_s  = req_a[win_idx_s*W +: W];
    win_b_s  = req_b[win_idx_s*W +: W];
    if (win_idx_s == PW'(N-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx_s + 1'b1;
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q;

  // WAIT-cycle counter; restarts from zero every time WAIT is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign expire_s = (wait_cnt_q == CW'(TIMEOUT - 1));
`else
  // A negative TIMEOUT is meaningless, so this is a constant 0: WAIT never expires.
  assign expire_s = (TIMEOUT < 0);
`endif

  // Sequencer FSM; every output is a register set on the transition into the state it belongs to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      zero_q      <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      rsp_err_q   <= 1'b0;
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_s) begin
            gnt_q       <= win_oh_s;
            owner_q     <= win_oh_s;
            div_a_q     <= win_a_s;
            div_b_q     <= win_b_s;
            zero_q      <= (win_b_s == '0);
            div_start_q <= (win_b_s != '0);
            ptr_q       <= ptr_d;
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        // The grant cycle; a zero divisor skips the divider and answers in the following cycle.
        S_ISSUE: begin
          if (zero_q) begin
            rsp_valid_q <= owner_q;
            rsp_q_q     <= '1;
            rsp_r_q     <= div_a_q;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_done) begin
            rsp_valid_q <= owner_q;
            rsp_q_q     <= div_q;
            rsp_r_q     <= div_r;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end else if (expire_s) begin
            div_abort_q <= 1'b1;
            rsp_valid_q <= owner_q;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_err   = rsp_err_q;
  assign div_start = div_start_q;
  assign div_abort = div_abort_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: directed operations push expected grants/responses, a monitor compares.
module tb_div_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_q;
  logic [W-1:0]   rsp_r;
  logic           rsp_err;
  logic           div_start;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_abort;
  logic           div_done;
  logic [W-1:0]   div_q;
  logic [W-1:0]   div_r;
  logic           busy;

  div_arbiter #(.N(N), .W(W), .TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_abort(div_abort),
    .div_done(div_done), .div_q(div_q), .div_r(div_r), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] oh;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } rsp_t;

  rsp_t         exp_rsp[$];
  logic [N-1:0] exp_gnt[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int gnt_cyc = 0;
  int rsp_cyc = 0;
  int done_cyc = 0;
  logic hold_req = 1'b0;
  rsp_t         mon_r;
  logic [N-1:0] mon_g;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] oh, input logic [W-1:0] q, input logic [W-1:0] r,
                      input logic err);
    rsp_t e;
    e.oh = oh; e.q = q; e.r = r; e.err = err;
    exp_rsp.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a response.
  initial begin
    forever begin
      @(negedge clock);
      if (div_start) n_start++;
      if (gnt != '0) begin
        gnt_cyc = cyc;
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
        else begin
          mon_g = exp_gnt.pop_front();
          chk("gnt", 64'(gnt), 64'(mon_g));
        end
      end
      if (rsp_valid != '0) begin
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(mon_r.oh));
          chk("rsp_q", 64'(rsp_q), 64'(mon_r.q));
          chk("rsp_r", 64'(rsp_r), 64'(mon_r.r));
          chk("rsp_err", 64'(rsp_err), 64'(mon_r.err));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (!hold_req) req = req & ~gnt;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req[i] = 1'b1;
  endtask

  task automatic wait_gnt(input string nm);
    int c = 0;
    tick();
    while (gnt == '0 && c < 50) begin tick(); c++; end
    chk(nm, 64'(gnt != '0), 64'd1);
  endtask

  // Divider model: waits for div_start, checks operand stability, answers after lat cycles.
  task automatic run_div(input int lat);
    int c = 0;
    logic [W-1:0] a, b;
    logic stable;
    tick();
    while (!div_start && c < 50) begin tick(); c++; end
    chk("div_start_seen", 64'(div_start), 64'd1);
    a = div_a; b = div_b; stable = 1'b1;
    repeat (lat) begin
      tick();
      if (div_a !== a || div_b !== b) stable = 1'b0;
    end
    chk("operands_stable", 64'(stable), 64'd1);
    div_done = 1'b1; div_q = a / b; div_r = a % b; done_cyc = cyc;
    tick();
    div_done = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while ((exp_rsp.size() != 0 || busy === 1'b1) && c < 3000) begin tick(); c++; end
    chk({"drain_", nm}, 64'(c < 3000), 64'd1);
  endtask

  initial begin
    int s0, c;
    logic [W-1:0] ca, cb;
    logic stable, flag_a, flag_b;
    req = '0; req_a = '0; req_b = '0; div_done = 1'b0; div_q = '0; div_r = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", 64'({gnt, rsp_valid, rsp_err, div_start, div_abort, busy}), 64'd0);
    chk("rst_data", 64'(rsp_q | rsp_r | div_a | div_b), 64'd0);
    reset_n = 1'b1;
    tick();

    // Round-robin with all requests held
    hold_req = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'(30 + i), 32'd3);
    exp_gnt.push_back(4'b0001); push(4'b0001, 32'd10, 32'd0, 1'b0);
    exp_gnt.push_back(4'b0010); push(4'b0010, 32'd10, 32'd1, 1'b0);
    exp_gnt.push_back(4'b0100); push(4'b0100, 32'd10, 32'd2, 1'b0);
    exp_gnt.push_back(4'b1000); push(4'b1000, 32'd11, 32'd0, 1'b0);
    exp_gnt.push_back(4'b0001); push(4'b0001, 32'd10, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) run_div(3 + k);
    req = '0; hold_req = 1'b0;
    wait_drain("rr");

    // Single divide 100/7 with a 33-cycle divider
    s0 = n_start;
    set_op(0, 32'd100, 32'd7);
    exp_gnt.push_back(4'b0001); push(4'b0001, 32'd14, 32'd2, 1'b0);
    run_div(33);
    wait_drain("single");
    chk("single_starts", 64'(n_start - s0), 64'd1);
    chk("single_rsp_latency", 64'(rsp_cyc - done_cyc), 64'd1);

    // Divide by zero trapped without touching the divider
    s0 = n_start;
    set_op(2, 32'd55, 32'd0);
    exp_gnt.push_back(4'b0100); push(4'b0100, 32'hFFFF_FFFF, 32'd55, 1'b1);
    wait_drain("divzero");
    chk("divzero_starts", 64'(n_start - s0), 64'd0);
    chk("divzero_latency", 64'(rsp_cyc - gnt_cyc), 64'd1);
    repeat (3) tick();
    chk("rsp_q_hold", 64'(rsp_q), 64'hFFFF_FFFF);

    // Stray div_done in IDLE and ISSUE must be ignored
    div_done = 1'b1; div_q = 32'hDEAD; div_r = 32'hBEEF;
    tick();
    div_done = 1'b0;
    tick();
    chk("stray_idle_busy", 64'(busy), 64'd0);
    set_op(1, 32'd1000, 32'd9);
    exp_gnt.push_back(4'b0010); push(4'b0010, 32'd111, 32'd1, 1'b0);
    wait_gnt("stray_gnt_seen");
    chk("stray_start_with_gnt", 64'(div_start), 64'd1);
    ca = div_a; cb = div_b; stable = 1'b1;
    div_done = 1'b1; div_q = 32'hDEAD; div_r = 32'hBEEF;
    tick();
    div_done = 1'b0;
    repeat (6) begin
      if (div_a !== ca || div_b !== cb) stable = 1'b0;
      tick();
    end
    chk("stray_stable", 64'(stable), 64'd1);
    chk("stray_div_a", 64'(ca), 64'd1000);
    chk("stray_div_b", 64'(cb), 64'd9);
    div_done = 1'b1; div_q = 32'd111; div_r = 32'd1;
    tick();
    div_done = 1'b0;
    wait_drain("stray");

    // Reset during WAIT discards the operation and clears the pointer
    set_op(0, 32'd9, 32'd2);
    exp_gnt.push_back(4'b0001);
    wait_gnt("midrst_gnt_seen");
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp", 64'(rsp_valid), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    div_done = 1'b1; div_q = 32'd4; div_r = 32'd1;
    tick();
    div_done = 1'b0;
    repeat (4) tick();
    chk("midrst_idle", 64'(busy), 64'd0);
    set_op(0, 32'd20, 32'd6);
    set_op(1, 32'd21, 32'd4);
    exp_gnt.push_back(4'b0001); push(4'b0001, 32'd3, 32'd2, 1'b0);
    exp_gnt.push_back(4'b0010); push(4'b0010, 32'd5, 32'd1, 1'b0);
    run_div(2);
    run_div(2);
    wait_drain("after_rst");

    // Divider that never finishes
    set_op(3, 32'd50, 32'd5);
    exp_gnt.push_back(4'b1000);
`ifdef DIV_ARB_TIMEOUT_EN
    push(4'b1000, 32'd0, 32'd0, 1'b1);
    c = 0;
    tick();
    while (!div_start && c < 50) begin tick(); c++; end
    chk("to_start_seen", 64'(div_start), 64'd1);
    c = 0;
    while (!div_abort && c < 200) begin tick(); c++; end
    chk("to_abort_latency", 64'(c), 64'd65);
    tick();
    chk("to_abort_pulse", 64'(div_abort), 64'd0);
    wait_drain("timeout");
`else
    c = 0;
    tick();
    while (!div_start && c < 50) begin tick(); c++; end
    chk("hang_start_seen", 64'(div_start), 64'd1);
    flag_a = 1'b0; flag_b = 1'b0;
    repeat (100) begin
      tick();
      if (busy !== 1'b1) flag_a = 1'b1;
      if (div_abort !== 1'b0) flag_b = 1'b1;
    end
    chk("hang_busy_held", 64'(flag_a), 64'd0);
    chk("hang_no_abort", 64'(flag_b), 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
`endif
    chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
